mc_fifo_buf: RTL and testbench

MC_FIFO_BUF -- requirements
Module: mc_fifo_buf

---
 rtl/mc_fifo_buf.sv | 157 +++++++++++++++
 tb/tb_mc_fifo_buf.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_fifo_buf.sv
// mc_fifo_buf -- multi-channel FIFO buffer.
//
// NUM_CH independent circular buffers of DEPTH words each share a single
// write port and a single read port. The channel for each access is chosen
// per cycle by wr_ch / rd_ch.
//
// Request semantics (both ports): a request is presented by holding wr_en /
// rd_en high for one clock edge with the channel (and data) stable. There is
// no back-pressure signal; a request the buffer cannot honour is dropped at
// that edge and reported one cycle later on ovf_err (write) or udf_err (read).
// An accepted read returns its word on rd_data with rd_valid high in the
// following cycle.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   wr_en/wr_ch/wr_data   write request, channel, data
//   rd_en/rd_ch           read request, channel
//   rd_data/rd_valid      registered read data and its one-cycle qualifier
//   empty/full            per-channel registered flags
//   count                 per-channel occupancy, channel k at [k*OW +: OW]
//   ovf_err/udf_err       one-cycle pulses for a dropped write / refused read
//   almost_full           per-channel (count >= AF_THRESH); present only when
//                         MC_FIFO_BUF_ALMOST_FULL_EN is defined
module mc_fifo_buf #(
    parameter int WIDTH     = 512,
    parameter int DEPTH     = 8,
    parameter int NUM_CH    = 4,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(NUM_CH),
    localparam int OW = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_ch,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_ch,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic [NUM_CH-1:0]    empty,
    output logic [NUM_CH-1:0]    full,
    output logic [NUM_CH*OW-1:0] count,
    output logic                 ovf_err,
    output logic                 udf_err
`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
    ,
    output logic [NUM_CH-1:0]    almost_full
`endif
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mc_fifo_buf: DEPTH must be a power of two and at least 2");
    end
    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("mc_fifo_buf: NUM_CH must be at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
        $error("mc_fifo_buf: AF_THRESH must lie in 0..DEPTH");
    end

    localparam logic [CW:0]   NUM_CH_L = (CW + 1)'(NUM_CH);
    localparam logic [OW-1:0] DEPTH_L  = OW'(DEPTH);

    logic [WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [AW-1:0]    wr_ptr [NUM_CH];
    logic [AW-1:0]    rd_ptr [NUM_CH];
    logic [OW-1:0]    cnt    [NUM_CH];
    logic [OW-1:0]    cnt_nxt[NUM_CH];

    logic wr_in_range;
    logic rd_in_range;
    logic rd_acc;
    logic wr_acc;

    // Acceptance uses the registered flags, so a read of an empty channel is
    // refused even if the same channel is written in this cycle (no bypass).
    // A full channel still takes a write when the same channel is also read,
    // because that read frees the slot the write lands in.
    always_comb begin
        wr_in_range = ({1'b0, wr_ch} < NUM_CH_L);
        rd_in_range = ({1'b0, rd_ch} < NUM_CH_L);
        rd_acc      = rd_en && rd_in_range && !empty[rd_ch];
        wr_acc      = wr_en && wr_in_range &&
                      (!full[wr_ch] || (rd_acc && (rd_ch == wr_ch)));
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_nxt[k] = cnt[k];
            if (wr_acc && (wr_ch == CW'(k))) cnt_nxt[k] = cnt_nxt[k] + OW'(1);
            if (rd_acc && (rd_ch == CW'(k))) cnt_nxt[k] = cnt_nxt[k] - OW'(1);
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            count[k*OW +: OW] = cnt[k];
        end
    end

    // Storage is not reset; writes presented during reset are ignored.
    // When a full channel is read and written together, wr_ptr == rd_ptr and
    // the read below still sees the old (oldest) word through the NBA.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem[wr_ch][wr_ptr[wr_ch]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
            empty    <= '1;
            full     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf_err  <= 1'b0;
            udf_err  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so AW-bit increments wrap to 0 naturally.
            if (wr_acc) wr_ptr[wr_ch] <= wr_ptr[wr_ch] + AW'(1);
            if (rd_acc) begin
                rd_ptr[rd_ch] <= rd_ptr[rd_ch] + AW'(1);
                rd_data       <= mem[rd_ch][rd_ptr[rd_ch]];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]   <= cnt_nxt[k];
                empty[k] <= (cnt_nxt[k] == '0);
                full[k]  <= (cnt_nxt[k] == DEPTH_L);
            end
            rd_valid <= rd_acc;
            ovf_err  <= wr_en && !wr_acc;
            udf_err  <= rd_en && !rd_acc;
        end
    end

`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
    localparam logic [OW-1:0] AF_L = OW'(AF_THRESH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            almost_full <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                almost_full[k] <= (cnt_nxt[k] >= AF_L);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_fifo_buf.sv
// Self-checking bench for mc_fifo_buf (WIDTH=32, DEPTH=8, NUM_CH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so each value observed reflects the edge just taken.
module tb_mc_fifo_buf;
    localparam int W  = 32;
    localparam int OW = 4;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [1:0]    rd_ch;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [15:0]   count;
    logic          ovf_err;
    logic          udf_err;
`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
    logic [3:0]    almost_full;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;

    mc_fifo_buf #(.WIDTH(W), .DEPTH(8), .NUM_CH(4)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count),
        .ovf_err(ovf_err), .udf_err(udf_err)
`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
        , .almost_full(almost_full)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic logic [OW-1:0] cnt_of(input int k);
        return count[k*OW +: OW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [W-1:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop(input logic [1:0] ch);
        rd_en = 1'b1; rd_ch = ch;
        step();
        rd_en = 1'b0;
    endtask

    task automatic push_pop(input logic [1:0] wch, input logic [W-1:0] d,
                            input logic [1:0] rch);
        wr_en = 1'b1; wr_ch = wch; wr_data = d;
        rd_en = 1'b1; rd_ch = rch;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Pops one word from channel ch and compares against the queue head.
    task automatic pop_check(input logic [1:0] ch, input string name);
        exp = exp_q.pop_front();
        pop(ch);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++;
            $display("FAIL %s: rd_valid=%b rd_data=%h, required rd_valid=1 rd_data=%h",
                     name, rd_valid, rd_data, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (empty !== 4'hf || full !== 4'h0 || count !== 16'h0) begin
            failures++;
            $display("FAIL reset_flags: empty=%h full=%h count=%h, required f 0 0",
                     empty, full, count);
        end
        checks++;
        if (rd_valid !== 1'b0 || ovf_err !== 1'b0 || udf_err !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outs: rd_valid=%b ovf=%b udf=%b rd_data=%h, required all 0",
                     rd_valid, ovf_err, udf_err, rd_data);
        end
`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
        checks++;
        if (almost_full !== 4'h0) begin
            failures++;
            $display("FAIL reset_af: almost_full=%h, required 0", almost_full);
        end
`endif
        reset = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push(2'd2, 32'h200 + W'(i));
            exp_q.push_back(32'h200 + W'(i));
        end
        checks++;
        if (full[2] !== 1'b1 || cnt_of(2) !== 4'd8 || empty[2] !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full2=%b count2=%0d empty2=%b, required 1 8 0",
                     full[2], cnt_of(2), empty[2]);
        end
        push(2'd2, 32'hdead);
        checks++;
        if (ovf_err !== 1'b1 || cnt_of(2) !== 4'd8 || full[2] !== 1'b1) begin
            failures++;
            $display("FAIL fill_ovf: ovf_err=%b count2=%0d full2=%b, required 1 8 1",
                     ovf_err, cnt_of(2), full[2]);
        end
        step();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL fill_ovf_pulse: ovf_err=%b, required 0", ovf_err);
        end
        for (int i = 0; i < 8; i++) pop_check(2'd2, "fill_drain");
        checks++;
        if (empty[2] !== 1'b1 || full[2] !== 1'b0 || cnt_of(2) !== 4'd0) begin
            failures++;
            $display("FAIL fill_empty: empty2=%b full2=%b count2=%0d, required 1 0 0",
                     empty[2], full[2], cnt_of(2));
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            push(2'd0, 32'hA00 + W'(i));
            exp_q.push_back(32'hA00 + W'(i));
        end
        for (int i = 0; i < 5; i++) pop_check(2'd0, "wrap_pop5");
        for (int i = 0; i < 5; i++) begin
            push(2'd0, 32'hB00 + W'(i));
            exp_q.push_back(32'hB00 + W'(i));
        end
        checks++;
        if (cnt_of(0) !== 4'd8 || full[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_refill: count0=%0d full0=%b, required 8 1", cnt_of(0), full[0]);
        end
        for (int i = 0; i < 8; i++) pop_check(2'd0, "wrap_pop8");
        step();
        checks++;
        if (empty[0] !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'hB04) begin
            failures++;
            $display("FAIL wrap_hold: empty0=%b rd_valid=%b rd_data=%h, required 1 0 b04",
                     empty[0], rd_valid, rd_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            push(2'd1, 32'hC00 + W'(i));
            exp_q.push_back(32'hC00 + W'(i));
        end
        exp = exp_q.pop_front();
        exp_q.push_back(32'hD00);
        push_pop(2'd1, 32'hD00, 2'd1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || cnt_of(1) !== 4'd8 ||
            ovf_err !== 1'b0 || full[1] !== 1'b1) begin
            failures++;
            $display("FAIL simul_full: rd_valid=%b rd_data=%h count1=%0d ovf=%b full1=%b, required 1 %h 8 0 1",
                     rd_valid, rd_data, cnt_of(1), ovf_err, full[1], exp);
        end
        for (int i = 0; i < 8; i++) pop_check(2'd1, "simul_drain");
    endtask

    task automatic test_isolation();
        // exp_q holds channel 3 order; channel 0 is checked with constants.
        push(2'd0, 32'hE00);
        push(2'd3, 32'hF00); exp_q.push_back(32'hF00);
        push(2'd3, 32'hF01); exp_q.push_back(32'hF01);
        exp = exp_q.pop_front();
        push_pop(2'd0, 32'hE01, 2'd3);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++;
            $display("FAIL iso_mixed: rd_valid=%b rd_data=%h, required 1 %h", rd_valid, rd_data, exp);
        end
        push(2'd3, 32'hF02); exp_q.push_back(32'hF02);
        pop_check(2'd3, "iso_ch3");
        pop_check(2'd3, "iso_ch3");
        checks++;
        if (cnt_of(0) !== 4'd2 || empty[3] !== 1'b1) begin
            failures++;
            $display("FAIL iso_counts: count0=%0d empty3=%b, required 2 1", cnt_of(0), empty[3]);
        end
        exp_q.push_back(32'hE00);
        exp_q.push_back(32'hE01);
        pop_check(2'd0, "iso_ch0");
        pop_check(2'd0, "iso_ch0");
    endtask

    task automatic test_underflow();
        push_pop(2'd1, 32'h600, 2'd1);
        checks++;
        if (udf_err !== 1'b1 || rd_valid !== 1'b0 || cnt_of(1) !== 4'd1 ||
            rd_data !== 32'hE01 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL underflow: udf=%b rd_valid=%b count1=%0d rd_data=%h ovf=%b, required 1 0 1 e01 0",
                     udf_err, rd_valid, cnt_of(1), rd_data, ovf_err);
        end
        exp_q.push_back(32'h600);
        pop_check(2'd1, "underflow_drain");
        checks++;
        if (udf_err !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pulse: udf_err=%b, required 0", udf_err);
        end
    endtask

    task automatic test_reset_mid();
        push(2'd0, 32'h700);
        push(2'd0, 32'h701);
        push(2'd0, 32'h702);
        push(2'd2, 32'h720);
        checks++;
        if (cnt_of(0) !== 4'd3 || cnt_of(2) !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_pre: count0=%0d count2=%0d, required 3 1", cnt_of(0), cnt_of(2));
        end
        reset = 1'b0;
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 32'h7ff;
        rd_en = 1'b1; rd_ch = 2'd2;
        step();
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 16'h0 || empty !== 4'hf || full !== 4'h0 ||
            rd_valid !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL rstmid_state: count=%h empty=%h full=%h rd_valid=%b rd_data=%h, required 0 f 0 0 0",
                     count, empty, full, rd_valid, rd_data);
        end
        pop(2'd0);
        checks++;
        if (udf_err !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_discard: udf=%b rd_valid=%b, required 1 0", udf_err, rd_valid);
        end
        push(2'd0, 32'h710);
        exp_q.push_back(32'h710);
        pop_check(2'd0, "rstmid_after");
    endtask

`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
    task automatic test_almost_full();
        for (int i = 0; i < 5; i++) push(2'd3, 32'h300 + W'(i));
        checks++;
        if (almost_full[3] !== 1'b0 || cnt_of(3) !== 4'd5) begin
            failures++;
            $display("FAIL af_below: almost_full3=%b count3=%0d, required 0 5", almost_full[3], cnt_of(3));
        end
        push(2'd3, 32'h305);
        checks++;
        if (almost_full !== 4'b1000) begin
            failures++;
            $display("FAIL af_at: almost_full=%b, required 1000", almost_full);
        end
        pop(2'd3);
        checks++;
        if (almost_full[3] !== 1'b0) begin
            failures++;
            $display("FAIL af_drop: almost_full3=%b, required 0", almost_full[3]);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        rd_en = 1'b0; rd_ch = '0;
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_isolation();
        test_underflow();
        test_reset_mid();
`ifdef MC_FIFO_BUF_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
